// File: rtl/instruction_fetch_unit.sv
// Fetch stage: owns the PC, drives the imem read port and buffers bytes in a prefetch FIFO.
// Optional FETCH_LAST_ADDR_HALT_EN: stop fetching after last_add_i, resume on redirect.
module instruction_fetch_unit #(
  parameter int unsigned       ADDR_W     = 8,
  parameter int unsigned       DATA_W     = 8,
  parameter int unsigned       FIFO_DEPTH = 2,
  parameter logic [ADDR_W-1:0] RESET_PC   = '0
) (
  input  logic              clk_i,
  input  logic              rst_n,
  input  logic              en_i,
  output logic [ADDR_W-1:0] imem_addr_o,
  output logic              imem_rd_en_o,
  input  logic [DATA_W-1:0] imem_rdata_i,
  input  logic              redirect_i,
  input  logic [ADDR_W-1:0] redirect_addr_i,
  input  logic [ADDR_W-1:0] last_add_i,
  output logic [DATA_W-1:0] instr_o,
  output logic [ADDR_W-1:0] instr_pc_o,
  output logic              instr_valid_o,
  input  logic              instr_ready_i,
  output logic              halted_o
);

  localparam int unsigned PtrW = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam int unsigned CntW = $clog2(FIFO_DEPTH + 1);
  localparam int unsigned OccW = CntW + 1;

  typedef enum logic [1:0] {StIdle, StFetch, StHalt} state_e;

  state_e            state_q, state_d;
  logic [ADDR_W-1:0] pc_q, pc_d;
  logic [DATA_W-1:0] fifo_data_q [FIFO_DEPTH];
  logic [ADDR_W-1:0] fifo_pc_q   [FIFO_DEPTH];
  logic [PtrW-1:0]   wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [CntW-1:0]   count_q, count_d;
  logic              inflight_q, inflight_d;
  logic [ADDR_W-1:0] inflight_pc_q, inflight_pc_d;
  logic              inflight_epoch_q, inflight_epoch_d;
  logic              epoch_q, epoch_d;
  logic [OccW-1:0]   occupancy;
  logic              room, issue, push, pop, last_hit;

  function automatic logic [PtrW-1:0] ptr_inc(input logic [PtrW-1:0] p);
    return (p == PtrW'(FIFO_DEPTH - 1)) ? '0 : p + PtrW'(1);
  endfunction

  assign pop       = (count_q != '0) && instr_ready_i;
  // A pop this cycle frees a slot, so an issue is allowed even at full occupancy.
  assign occupancy = {1'b0, count_q} + OccW'(inflight_q);
  assign room      = (occupancy < OccW'(FIFO_DEPTH)) || pop;
  assign issue     = (state_q == StFetch) && en_i && !redirect_i && room;
  // Responses from before the last redirect carry the old epoch and are dropped.
  assign push      = inflight_q && (inflight_epoch_q == epoch_q) && !redirect_i;

`ifdef FETCH_LAST_ADDR_HALT_EN
  assign last_hit = issue && (pc_q == last_add_i);
  assign halted_o = (state_q == StHalt) && (count_q == '0) && !inflight_q;
`else
  logic unused_last_add;
  assign unused_last_add = ^last_add_i;
  assign last_hit        = 1'b0;
  assign halted_o        = 1'b0;
`endif

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      StIdle:  if (en_i) state_d = StFetch;
      StFetch: begin
        if (!en_i)         state_d = StIdle;
        else if (last_hit) state_d = StHalt;
      end
      StHalt:  if (redirect_i) state_d = en_i ? StFetch : StIdle;
      default: state_d = StIdle;
    endcase
  end

  always_comb begin
    pc_d             = pc_q;
    inflight_d       = issue;
    inflight_pc_d    = issue ? pc_q : inflight_pc_q;
    inflight_epoch_d = epoch_q;
    epoch_d          = epoch_q ^ redirect_i;
    wr_ptr_d         = wr_ptr_q;
    rd_ptr_d         = rd_ptr_q;
    count_d          = count_q;
    if (redirect_i) begin
      pc_d     = redirect_addr_i;
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      count_d  = '0;
    end else begin
      if (issue) pc_d = pc_q + ADDR_W'(1);
      if (push)  wr_ptr_d = ptr_inc(wr_ptr_q);
      if (pop)   rd_ptr_d = ptr_inc(rd_ptr_q);
      count_d = count_q + CntW'(push) - CntW'(pop);
    end
  end

  always_ff @(posedge clk_i or negedge rst_n) begin
    if (!rst_n) begin
      state_q          <= StIdle;
      pc_q             <= RESET_PC;
      wr_ptr_q         <= '0;
      rd_ptr_q         <= '0;
      count_q          <= '0;
      inflight_q       <= 1'b0;
      inflight_pc_q    <= '0;
      inflight_epoch_q <= 1'b0;
      epoch_q          <= 1'b0;
      for (int unsigned i = 0; i < FIFO_DEPTH; i++) begin
        fifo_data_q[i] <= '0;
        fifo_pc_q[i]   <= '0;
      end
    end else begin
      state_q          <= state_d;
      pc_q             <= pc_d;
      wr_ptr_q         <= wr_ptr_d;
      rd_ptr_q         <= rd_ptr_d;
      count_q          <= count_d;
      inflight_q       <= inflight_d;
      inflight_pc_q    <= inflight_pc_d;
      inflight_epoch_q <= inflight_epoch_d;
      epoch_q          <= epoch_d;
      if (push) begin
        fifo_data_q[wr_ptr_q] <= imem_rdata_i;
        fifo_pc_q[wr_ptr_q]   <= inflight_pc_q;
      end
    end
  end

  assign imem_rd_en_o  = issue;
  assign imem_addr_o   = pc_q;
  assign instr_valid_o = (count_q != '0);
  assign instr_o       = instr_valid_o ? fifo_data_q[rd_ptr_q] : '0;
  assign instr_pc_o    = instr_valid_o ? fifo_pc_q[rd_ptr_q] : '0;

endmodule

// File: tb/tb_instruction_fetch_unit.sv
// Bench for instruction_fetch_unit: cycle-exact vector table plus a scoreboard of the
// expected decoder stream; the halt sequence follows FETCH_LAST_ADDR_HALT_EN.
module tb_instruction_fetch_unit;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       en = 1'b0;
  logic       redirect = 1'b0;
  logic       instr_ready = 1'b0;
  logic [7:0] redirect_addr = 8'h00;
  logic [7:0] last_add = 8'h80;
  logic [7:0] imem_rdata = 8'h00;
  logic [7:0] imem_addr, instr, instr_pc;
  logic       imem_rd_en, instr_valid, halted;

  int n_checks = 0;
  int n_fail   = 0;
  int issue_cnt = 0;
  int pop_cnt   = 0;
  logic [7:0] last_pc = 8'h00;

  typedef struct packed {
    logic [7:0] instr;
    logic [7:0] pc;
  } sb_t;
  sb_t sb_q[$];

  typedef struct packed {
    logic       en;
    logic       ready;
    logic       redir;
    logic [7:0] raddr;
    logic       exp_valid;
    logic [7:0] exp_instr;
    logic [7:0] exp_pc;
    logic       exp_rd_en;
    logic [7:0] exp_addr;
  } vec_t;
  vec_t vecs[26];

  instruction_fetch_unit #(
    .ADDR_W(8), .DATA_W(8), .FIFO_DEPTH(2), .RESET_PC(8'h00)
  ) dut (
    .clk_i          (clk),
    .rst_n          (rst_n),
    .en_i           (en),
    .imem_addr_o    (imem_addr),
    .imem_rd_en_o   (imem_rd_en),
    .imem_rdata_i   (imem_rdata),
    .redirect_i     (redirect),
    .redirect_addr_i(redirect_addr),
    .last_add_i     (last_add),
    .instr_o        (instr),
    .instr_pc_o     (instr_pc),
    .instr_valid_o  (instr_valid),
    .instr_ready_i  (instr_ready),
    .halted_o       (halted)
  );

  always #5 clk = ~clk;

  // Synchronous instruction memory with imem[k] = k + 8'h10.
  always @(posedge clk) if (imem_rd_en) imem_rdata <= imem_addr + 8'h10;

  task automatic check(input string name, input logic [7:0] act, input logic [7:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic sb_restart(input logic [7:0] start);
    logic [7:0] p;
    sb_q.delete();
    for (int k = 0; k < 64; k++) begin
      p = start + 8'(k);
      sb_q.push_back('{instr: p + 8'h10, pc: p});
    end
  endtask

  task automatic cycle(input logic e, input logic r, input logic rd, input logic [7:0] ra);
    sb_t exp;
    @(negedge clk);
    en = e; instr_ready = r; redirect = rd; redirect_addr = ra;
    #1;
    if (imem_rd_en) issue_cnt++;
    if (instr_valid && instr_ready) begin
      pop_cnt++;
      last_pc = instr_pc;
      n_checks++;
      if (sb_q.size() == 0) begin
        n_fail++;
        $display("FAIL sb_underflow: got pc %h, no entry expected", instr_pc);
      end else begin
        exp = sb_q.pop_front();
        check("sb_instr", instr, exp.instr);
        check("sb_pc", instr_pc, exp.pc);
      end
    end
    if (rd) sb_restart(ra);
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_valid"}, {7'b0, instr_valid}, 8'h00);
    check({tag, "_rd_en"}, {7'b0, imem_rd_en}, 8'h00);
    check({tag, "_addr"}, imem_addr, 8'h00);
    check({tag, "_instr"}, instr, 8'h00);
    check({tag, "_instr_pc"}, instr_pc, 8'h00);
    check({tag, "_halted"}, {7'b0, halted}, 8'h00);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish within time limit");
    $fatal(1, "watchdog");
  end

  initial begin
    // en ready redir raddr | valid instr pc | rd_en addr
    vecs[0]  = '{1'b1, 1'b1, 1'b0, 8'h00, 1'b0, 8'h00, 8'h00, 1'b0, 8'h00};
    vecs[1]  = '{1'b1, 1'b1, 1'b0, 8'h00, 1'b0, 8'h00, 8'h00, 1'b1, 8'h00};
    vecs[2]  = '{1'b1, 1'b1, 1'b0, 8'h00, 1'b0, 8'h00, 8'h00, 1'b1, 8'h01};
    vecs[3]  = '{1'b1, 1'b1, 1'b0, 8'h00, 1'b1, 8'h10, 8'h00, 1'b1, 8'h02};
    vecs[4]  = '{1'b1, 1'b1, 1'b0, 8'h00, 1'b1, 8'h11, 8'h01, 1'b1, 8'h03};
    vecs[5]  = '{1'b1, 1'b1, 1'b0, 8'h00, 1'b1, 8'h12, 8'h02, 1'b1, 8'h04};
    vecs[6]  = '{1'b1, 1'b0, 1'b0, 8'h00, 1'b1, 8'h13, 8'h03, 1'b0, 8'h05};
    vecs[7]  = '{1'b1, 1'b0, 1'b0, 8'h00, 1'b1, 8'h13, 8'h03, 1'b0, 8'h05};
    vecs[8]  = '{1'b1, 1'b0, 1'b0, 8'h00, 1'b1, 8'h13, 8'h03, 1'b0, 8'h05};
    vecs[9]  = '{1'b1, 1'b0, 1'b0, 8'h00, 1'b1, 8'h13, 8'h03, 1'b0, 8'h05};
    vecs[10] = '{1'b1, 1'b0, 1'b0, 8'h00, 1'b1, 8'h13, 8'h03, 1'b0, 8'h05};
    vecs[11] = '{1'b1, 1'b1, 1'b0, 8'h00, 1'b1, 8'h13, 8'h03, 1'b1, 8'h05};
    vecs[12] = '{1'b1, 1'b1, 1'b0, 8'h00, 1'b1, 8'h14, 8'h04, 1'b1, 8'h06};
    vecs[13] = '{1'b1, 1'b1, 1'b0, 8'h00, 1'b1, 8'h15, 8'h05, 1'b1, 8'h07};
    vecs[14] = '{1'b1, 1'b1, 1'b0, 8'h00, 1'b1, 8'h16, 8'h06, 1'b1, 8'h08};
    vecs[15] = '{1'b1, 1'b0, 1'b1, 8'h40, 1'b1, 8'h17, 8'h07, 1'b0, 8'h09};
    vecs[16] = '{1'b1, 1'b1, 1'b0, 8'h00, 1'b0, 8'h00, 8'h00, 1'b1, 8'h40};
    vecs[17] = '{1'b1, 1'b1, 1'b0, 8'h00, 1'b0, 8'h00, 8'h00, 1'b1, 8'h41};
    vecs[18] = '{1'b1, 1'b1, 1'b0, 8'h00, 1'b1, 8'h50, 8'h40, 1'b1, 8'h42};
    vecs[19] = '{1'b1, 1'b1, 1'b1, 8'hFE, 1'b1, 8'h51, 8'h41, 1'b0, 8'h43};
    vecs[20] = '{1'b1, 1'b1, 1'b0, 8'h00, 1'b0, 8'h00, 8'h00, 1'b1, 8'hFE};
    vecs[21] = '{1'b1, 1'b1, 1'b0, 8'h00, 1'b0, 8'h00, 8'h00, 1'b1, 8'hFF};
    vecs[22] = '{1'b1, 1'b1, 1'b0, 8'h00, 1'b1, 8'h0E, 8'hFE, 1'b1, 8'h00};
    vecs[23] = '{1'b1, 1'b1, 1'b0, 8'h00, 1'b1, 8'h0F, 8'hFF, 1'b1, 8'h01};
    vecs[24] = '{1'b1, 1'b1, 1'b0, 8'h00, 1'b1, 8'h10, 8'h00, 1'b1, 8'h02};
    vecs[25] = '{1'b1, 1'b1, 1'b0, 8'h00, 1'b1, 8'h11, 8'h01, 1'b1, 8'h03};

    // Reset state
    @(negedge clk);
    #1;
    check_reset_outputs("reset");
    @(negedge clk);
    rst_n = 1'b1;
    sb_restart(8'h00);

    // Startup latency, stall, redirect to 40 with slots full, redirect to FE with pop, wrap
    for (int i = 0; i < 26; i++) begin
      cycle(vecs[i].en, vecs[i].ready, vecs[i].redir, vecs[i].raddr);
      check($sformatf("v%0d_valid", i), {7'b0, instr_valid}, {7'b0, vecs[i].exp_valid});
      check($sformatf("v%0d_rd_en", i), {7'b0, imem_rd_en}, {7'b0, vecs[i].exp_rd_en});
      check($sformatf("v%0d_addr", i), imem_addr, vecs[i].exp_addr);
      if (vecs[i].exp_valid) begin
        check($sformatf("v%0d_instr", i), instr, vecs[i].exp_instr);
        check($sformatf("v%0d_instr_pc", i), instr_pc, vecs[i].exp_pc);
      end
    end

    // last_add = 05 from address 00: halts with the macro, free-runs without
    last_add = 8'h05;
    cycle(1'b1, 1'b1, 1'b1, 8'h00);
    issue_cnt = 0; pop_cnt = 0;
    for (int i = 0; i < 14; i++) cycle(1'b1, 1'b1, 1'b0, 8'h00);
`ifdef FETCH_LAST_ADDR_HALT_EN
    check("halt_issues", 8'(issue_cnt), 8'd6);
    check("halt_pops", 8'(pop_cnt), 8'd6);
    check("halt_last_pc", last_pc, 8'h05);
    check("halt_halted", {7'b0, halted}, 8'h01);
    check("halt_valid", {7'b0, instr_valid}, 8'h00);
`else
    check("run_issues", 8'(issue_cnt), 8'd14);
    check("run_pops", 8'(pop_cnt), 8'd12);
    check("run_last_pc", last_pc, 8'h0B);
    check("run_halted", {7'b0, halted}, 8'h00);
`endif

    // Redirect with en=0: PC loads, nothing issues until en returns
    last_add = 8'h80;
    cycle(1'b0, 1'b1, 1'b1, 8'h20);
    for (int i = 0; i < 3; i++) begin
      cycle(1'b0, 1'b1, 1'b0, 8'h00);
      check($sformatf("en0_rd_en_%0d", i), {7'b0, imem_rd_en}, 8'h00);
      check($sformatf("en0_valid_%0d", i), {7'b0, instr_valid}, 8'h00);
    end
    check("en0_addr", imem_addr, 8'h20);
    check("en0_halted", {7'b0, halted}, 8'h00);
    issue_cnt = 0; pop_cnt = 0;
    for (int i = 0; i < 6; i++) cycle(1'b1, 1'b1, 1'b0, 8'h00);
    check("en1_issues", 8'(issue_cnt), 8'd5);
    check("en1_pops", 8'(pop_cnt), 8'd3);
    check("en1_last_pc", last_pc, 8'h22);

    // Asynchronous reset in the middle of a cycle, then restart from RESET_PC
    @(negedge clk);
    #2;
    rst_n = 1'b0;
    #1;
    check_reset_outputs("async_rst");
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    sb_restart(8'h00);
    issue_cnt = 0; pop_cnt = 0;
    for (int i = 0; i < 8; i++) cycle(1'b1, 1'b1, 1'b0, 8'h00);
    check("restart_pops", 8'(pop_cnt), 8'd6);
    check("restart_last_pc", last_pc, 8'h05);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
